// File: rtl/sbox_pow_pkg.sv
// Shared types and GF(2^n) helpers for the sequential power-map S-box.
// Defaults target GF(64) with x^6+x+1.
package sbox_pow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int          DEF_N        = 6;
  localparam logic [6:0]  DEF_POLY     = 7'b1000011;
  localparam logic [5:0]  DEF_ADD_MASK = 6'b010100;

  // MSB-first shift-and-add multiply; operands must already be below 2^n,
  // so leading zero bits leave the partial product at zero.
  function automatic logic [15:0] gf_mul(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [16:0] poly,
                                         input logic [4:0]  n);
    logic [16:0] p;
    logic [15:0] b_sh;
    logic [16:0] top;
    p    = 17'd0;
    b_sh = b;
    top  = 17'd1 << n;
    for (int i = 0; i < 16; i++) begin
      p = p << 1;
      if ((p & top) != 17'd0) p = p ^ poly;
      else                    p = p;
      if (b_sh[15]) p = p ^ {1'b0, a};
      else          p = p;
      b_sh = b_sh << 1;
    end
    return p[15:0];
  endfunction

  function automatic logic parity16(input logic [15:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sbox_pow_seq_if.sv
// Input/output handshake bundle of the S-box; master drives requests,
// slave is the S-box itself.
interface sbox_pow_seq_if #(parameter int N = 6);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x_i;
  logic [N-1:0] exp_i;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y_o;
  logic         busy_o;

  modport master (
    output in_valid, x_i, exp_i, out_ready,
    input  in_ready, out_valid, y_o, busy_o
  );

  modport slave (
    input  in_valid, x_i, exp_i, out_ready,
    output in_ready, out_valid, y_o, busy_o
  );
endinterface

// File: rtl/gf2n_sqmul.sv
// One square-and-multiply step: res = acc^2 * (sel ? base : 1) mod POLY.
// Purely combinational.
module gf2n_sqmul
  import sbox_pow_pkg::*;
#(
  parameter int         N    = 6,
  parameter logic [N:0] POLY = (N+1)'(DEF_POLY)
) (
  input  logic [N-1:0] acc_i,
  input  logic [N-1:0] base_i,
  input  logic         sel_i,
  output logic [N-1:0] res_o
);

  logic [15:0] sq_s;
  logic [15:0] op_s;
  logic [15:0] mul_s;

  always_comb begin
    sq_s = gf_mul(16'(acc_i), 16'(acc_i), 17'(POLY), 5'(N));
    if (sel_i) op_s = 16'(base_i);
    else       op_s = 16'd1;
    mul_s = gf_mul(sq_s, op_s, 17'(POLY), 5'(N));
    res_o = N'(mul_s);
  end

endmodule

// File: rtl/sbox_pow_seq.sv
// Sequential power-map S-box y = x^e over GF(2^N), one exponent bit per cycle.
// Define SBOX_AFFINE_EN to XOR the parity of (x & ADD_MASK) into every output bit.
module sbox_pow_seq
  import sbox_pow_pkg::*;
#(
  parameter int           N        = 6,
  parameter logic [N:0]   POLY     = (N+1)'(DEF_POLY),
  parameter logic [N-1:0] ADD_MASK = N'(DEF_ADD_MASK)
) (
  input  logic          clk,
  input  logic          rst_n,
  sbox_pow_seq_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef SBOX_AFFINE_EN
  localparam logic AFFINE_ON = 1'b1;
`else
  localparam logic AFFINE_ON = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  base_q, base_d;
  logic [N-1:0]  exp_q, exp_d;
  logic [N-1:0]  y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sqmul_s;
  logic [N-1:0]  affine_s;
  logic          in_ready_s, out_valid_s, busy_s;

  // base_q doubles as the latched input used for the affine parity.
  assign affine_s = {N{AFFINE_ON & parity16(16'(base_q & ADD_MASK))}};

  gf2n_sqmul #(.N(N), .POLY(POLY)) u_sqmul (
    .acc_i  (acc_q),
    .base_i (base_q),
    .sel_i  (exp_q[cnt_q]),
    .res_o  (sqmul_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= {{(N-1){1'b0}}, 1'b1};
      base_q  <= {N{1'b0}};
      exp_q   <= {N{1'b0}};
      y_q     <= {N{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          base_d  = bus.x_i;
          exp_d   = bus.exp_i;
          acc_d   = {{(N-1){1'b0}}, 1'b1};
          cnt_d   = CW'(N-1);
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d = sqmul_s;
        // Result register loads on the last step so y_o is valid on DONE entry.
        if (cnt_q == {CW{1'b0}}) begin
          y_d     = sqmul_s ^ affine_s;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
        else               state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_q)
      ST_IDLE: in_ready_s  = 1'b1;
      ST_RUN:  busy_s      = 1'b1;
      ST_DONE: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.busy_o    = busy_s;
  assign bus.y_o       = y_q;

endmodule
